// File: rtl/imem_loader.sv
// imem_loader: loads instruction words into a small memory from a byte stream
// (length, high/low byte pairs, XOR checksum) while holding the CPU off.
// The memory read port is combinational, so the CPU sees data = mem[a] at all times.
module imem_loader #(
  parameter int DEPTH  = 16,
  parameter int MAXLEN = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        load_req,
  input  logic        byte_valid,
  input  logic [7:0]  byte_data,
  output logic        byte_ready,
  input  logic [3:0]  a,
  output logic [15:0] data,
  output logic        cpu_hold,
  output logic        load_done,
  output logic [4:0]  word_count,
  output logic        err
);

  localparam logic [2:0] IDLE = 3'd0;
  localparam logic [2:0] LEN  = 3'd1;
  localparam logic [2:0] HI   = 3'd2;
  localparam logic [2:0] LO   = 3'd3;
  localparam logic [2:0] CSUM = 3'd4;
  localparam logic [2:0] DONE = 3'd5;

  localparam logic [15:0] HALT_WORD = 16'h9000;

  logic [2:0]  state_r;
  logic [2:0]  next_state_s;
  logic [3:0]  ptr_r;
  logic [7:0]  csum_r;
  logic [7:0]  len_r;
  logic [7:0]  hi_r;
  logic        xfer_s;
  logic        len_ok_s;
  logic        last_word_s;
  logic        ready_next_s;
  logic [15:0] mem_r [DEPTH];

  assign xfer_s      = byte_valid & byte_ready;
  assign len_ok_s    = (byte_data != 8'd0) && (byte_data <= 8'(MAXLEN));
  assign last_word_s = (({3'd0, word_count} + 8'd1) == len_r);
  assign data        = mem_r[a];

  // Next-state decode; byte_ready and load_done are registered from it.
  always_comb begin
    next_state_s = state_r;
    case (state_r)
      IDLE: begin
        if (load_req) next_state_s = LEN;
        else          next_state_s = IDLE;
      end
      LEN: begin
        if (xfer_s) next_state_s = len_ok_s ? HI : IDLE;
        else        next_state_s = LEN;
      end
      HI: begin
        if (xfer_s) next_state_s = LO;
        else        next_state_s = HI;
      end
      LO: begin
        if (xfer_s) next_state_s = last_word_s ? CSUM : HI;
        else        next_state_s = LO;
      end
      CSUM: begin
        if (xfer_s) next_state_s = DONE;
        else        next_state_s = CSUM;
      end
      DONE:    next_state_s = IDLE;
      default: next_state_s = IDLE;
    endcase
  end

  // Byte acceptance is open only while a stream field is expected.
  always_comb begin
    ready_next_s = 1'b0;
    if ((next_state_s == LEN) || (next_state_s == HI) ||
        (next_state_s == LO) || (next_state_s == CSUM)) begin
      ready_next_s = 1'b1;
    end else begin
      ready_next_s = 1'b0;
    end
  end

  // Session control: state, handshake, hold, counters, checksum and error flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r    <= IDLE;
      byte_ready <= 1'b0;
      load_done  <= 1'b0;
      cpu_hold   <= 1'b0;
      word_count <= 5'd0;
      err        <= 1'b0;
      ptr_r      <= 4'd0;
      csum_r     <= 8'd0;
      len_r      <= 8'd0;
      hi_r       <= 8'd0;
    end else begin
      state_r    <= next_state_s;
      byte_ready <= ready_next_s;
      load_done  <= (next_state_s == DONE);
      case (state_r)
        IDLE: begin
          if (load_req) begin
            cpu_hold   <= 1'b1;
            word_count <= 5'd0;
            err        <= 1'b0;
            ptr_r      <= 4'd0;
            csum_r     <= 8'd0;
          end
        end
        LEN: begin
          if (xfer_s) begin
            if (len_ok_s) begin
              len_r <= byte_data;
            end else begin
              err      <= 1'b1;
              cpu_hold <= 1'b0;
            end
          end
        end
        HI: begin
          if (xfer_s) begin
            hi_r   <= byte_data;
            csum_r <= csum_r ^ byte_data;
          end
        end
        LO: begin
          if (xfer_s) begin
            csum_r     <= csum_r ^ byte_data;
            ptr_r      <= ptr_r + 4'd1;
            word_count <= word_count + 5'd1;
          end
        end
        CSUM: begin
          if (xfer_s && (byte_data != csum_r)) err <= 1'b1;
        end
        DONE:    cpu_hold <= 1'b0;
        default: cpu_hold <= 1'b0;
      endcase
    end
  end

  // Instruction memory: every word reset to the halt opcode, written on each low byte.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem_r[i] <= HALT_WORD;
    end else if ((state_r == LO) && xfer_s) begin
      mem_r[ptr_r] <= {hi_r, byte_data};
    end
  end

endmodule

// File: tb/tb_imem_loader.sv
// Self-checking bench for imem_loader: directed and random load sessions checked
// against a stream-level model of the memory image, word count, error and done pulses.
module tb_imem_loader;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        load_req = 1'b0;
  logic        byte_valid = 1'b0;
  logic [7:0]  byte_data = 8'd0;
  logic [3:0]  a = 4'd0;
  logic        byte_ready, cpu_hold, load_done, err;
  logic [15:0] data;
  logic [4:0]  word_count;

  int checks = 0;
  int errors = 0;
  int done_total = 0;
  int g_cnt = 0;
  bit g_err = 1'b0;
  logic [15:0] model_mem [16];
  logic [7:0]  stream_q [$];

  imem_loader #(.DEPTH(16), .MAXLEN(16)) dut (
    .clk(clk), .rst_n(rst_n), .load_req(load_req), .byte_valid(byte_valid),
    .byte_data(byte_data), .byte_ready(byte_ready), .a(a), .data(data),
    .cpu_hold(cpu_hold), .load_done(load_done), .word_count(word_count), .err(err)
  );

  always #5 clk = ~clk;

  // Count completion pulses, sampled mid-cycle.
  always @(negedge clk) if (load_done === 1'b1) done_total++;

  // Reference: what a whole stream must leave behind, from the stream rules alone.
  task automatic model_apply(output bit e_err, output int e_cnt, output int e_done, output bit bad);
    int n;
    logic [7:0] x;
    n = int'(stream_q[0]);
    x = 8'd0;
    if (n == 0 || n > 16) begin
      e_err = 1'b1; e_cnt = 0; e_done = 0; bad = 1'b1;
    end else begin
      for (int i = 0; i < n; i++) begin
        model_mem[i % 16] = {stream_q[1 + 2 * i], stream_q[2 + 2 * i]};
        x = x ^ stream_q[1 + 2 * i] ^ stream_q[2 + 2 * i];
      end
      e_err = (stream_q[2 * n + 1] != x); e_cnt = n; e_done = 1; bad = 1'b0;
    end
  endtask

  task automatic build_stream(input int n, input bit good_cs);
    logic [7:0] x, b;
    x = 8'd0;
    stream_q.delete();
    stream_q.push_back(8'(n));
    for (int i = 0; i < 2 * n; i++) begin
      b = 8'($urandom);
      x = x ^ b;
      stream_q.push_back(b);
    end
    stream_q.push_back(good_cs ? x : ~x);
  endtask

  // Offer the first count bytes of stream_q; optional gaps and ignored load_req noise.
  task automatic send_bytes(input int count, input bit gaps, input string name);
    int idx, budget;
    idx = 0; budget = 0;
    while (idx < count && budget < 4000) begin
      if (gaps && $urandom_range(0, 2) == 0) begin
        byte_valid = 1'b0; byte_data = 8'($urandom);
      end else begin
        byte_valid = 1'b1; byte_data = stream_q[idx];
      end
      load_req = gaps ? 1'($urandom_range(0, 1)) : 1'b0;
      if (byte_valid && byte_ready) idx++;
      @(negedge clk);
      budget++;
    end
    byte_valid = 1'b0; load_req = 1'b0;
    checks++;
    if (idx != count) begin
      errors++; $display("FAIL %s timeout: bytes sent %0d required %0d", name, idx, count);
    end
  endtask

  // One full session over stream_q; started=1 means LEN was already entered.
  task automatic run_load(input string name, input bit gaps, input bit started);
    bit e_err, bad;
    int e_cnt, e_done, base;
    model_apply(e_err, e_cnt, e_done, bad);
    if (!started) begin
      @(negedge clk); load_req = 1'b1;
      @(negedge clk); load_req = 1'b0;
    end
    checks++;
    if (!(cpu_hold === 1'b1 && byte_ready === 1'b1 && err === 1'b0 && word_count === 5'd0)) begin
      errors++; $display("FAIL %s start: hold/ready/err/wc %b%b%b/%0d required 110/0", name, cpu_hold, byte_ready, err, word_count);
    end
    base = done_total;
    send_bytes(stream_q.size(), gaps, name);
    if (!bad) begin
      checks++;
      if (!(load_done === 1'b1 && cpu_hold === 1'b1 && byte_ready === 1'b0)) begin
        errors++; $display("FAIL %s done_cycle: done/hold/ready %b%b%b required 110", name, load_done, cpu_hold, byte_ready);
      end
      @(negedge clk);
      checks++;
      if (!(load_done === 1'b0 && cpu_hold === 1'b0 && byte_ready === 1'b0)) begin
        errors++; $display("FAIL %s after_done: done/hold/ready %b%b%b required 000", name, load_done, cpu_hold, byte_ready);
      end
    end else begin
      checks++;
      if (!(err === 1'b1 && cpu_hold === 1'b0 && byte_ready === 1'b0 && load_done === 1'b0)) begin
        errors++; $display("FAIL %s len_abort: err/hold/ready/done %b%b%b%b required 1000", name, err, cpu_hold, byte_ready, load_done);
      end
    end
    repeat (2) @(negedge clk);
    checks++;
    if (done_total - base != e_done) begin
      errors++; $display("FAIL %s done_pulses: got %0d required %0d", name, done_total - base, e_done);
    end
    checks++;
    if (word_count !== 5'(e_cnt) || err !== e_err) begin
      errors++; $display("FAIL %s status: wc %0d err %b required wc %0d err %b", name, word_count, err, e_cnt, e_err);
    end
    for (int i = 0; i < 16; i++) begin
      a = 4'(i); #1;
      checks++;
      if (data !== model_mem[i]) begin
        errors++; $display("FAIL %s mem[%0d]: got %h required %h", name, i, data, model_mem[i]);
      end
    end
    g_cnt = e_cnt; g_err = e_err;
  endtask

  task automatic test_reset();
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({byte_ready, cpu_hold, load_done, err, word_count} !== 9'd0) begin
      errors++; $display("FAIL reset_outputs: ready/hold/done/err/wc %b%b%b%b/%0d required all 0", byte_ready, cpu_hold, load_done, err, word_count);
    end
    for (int i = 0; i < 16; i++) model_mem[i] = 16'h9000;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if ({byte_ready, cpu_hold, load_done, err, word_count} !== 9'd0) begin
      errors++; $display("FAIL after_reset_outputs: ready/hold/done/err/wc %b%b%b%b/%0d required all 0", byte_ready, cpu_hold, load_done, err, word_count);
    end
    for (int i = 0; i < 16; i++) begin
      a = 4'(i); #1;
      checks++;
      if (data !== 16'h9000) begin
        errors++; $display("FAIL reset_mem[%0d]: got %h required 9000", i, data);
      end
    end
  endtask

  task automatic test_basic();
    // Data bytes 10,23,04,51 XOR to 66.
    stream_q = '{8'h02, 8'h10, 8'h23, 8'h04, 8'h51, 8'h66};
    run_load("basic", 1'b0, 1'b0);
  endtask

  task automatic test_bad_checksum();
    stream_q = '{8'h02, 8'h10, 8'h23, 8'h04, 8'h51, 8'h00};
    run_load("bad_checksum", 1'b0, 1'b0);
  endtask

  task automatic test_bad_length();
    stream_q = '{8'h00};
    run_load("len_zero", 1'b0, 1'b0);
    stream_q = '{8'h11};
    run_load("len_17", 1'b0, 1'b0);
  endtask

  task automatic test_full_wrap();
    build_stream(16, 1'b1);
    run_load("full16", 1'b1, 1'b0);
    build_stream(1, 1'b1);
    run_load("after_wrap", 1'b0, 1'b0);
  endtask

  task automatic test_idle_ignored();
    repeat (5) begin
      byte_valid = 1'b1; byte_data = 8'($urandom);
      @(negedge clk);
    end
    byte_valid = 1'b0;
    checks++;
    if (byte_ready !== 1'b0 || cpu_hold !== 1'b0 || word_count !== 5'(g_cnt) || err !== g_err) begin
      errors++; $display("FAIL idle_ignored: ready/hold %b%b wc %0d err %b required 00 wc %0d err %b", byte_ready, cpu_hold, word_count, err, g_cnt, g_err);
    end
    for (int i = 0; i < 16; i++) begin
      a = 4'(i); #1;
      checks++;
      if (data !== model_mem[i]) begin
        errors++; $display("FAIL idle_mem[%0d]: got %h required %h", i, data, model_mem[i]);
      end
    end
  endtask

  task automatic test_random();
    int mode;
    for (int k = 0; k < 8; k++) begin
      mode = int'($urandom_range(0, 5));
      if (mode == 0) begin
        stream_q.delete();
        stream_q.push_back(($urandom_range(0, 1) == 0) ? 8'h00 : 8'($urandom_range(17, 255)));
      end else begin
        build_stream(int'($urandom_range(1, 16)), mode != 1);
      end
      run_load("random", 1'b1, 1'b0);
    end
  endtask

  task automatic test_reset_mid();
    int base;
    build_stream(2, 1'b1);
    @(negedge clk); load_req = 1'b1;
    @(negedge clk); load_req = 1'b0;
    send_bytes(4, 1'b0, "reset_mid_pre");
    base = done_total;
    byte_valid = 1'b1; byte_data = 8'h5a;
    rst_n = 1'b0;
    #1;
    for (int i = 0; i < 16; i++) model_mem[i] = 16'h9000;
    checks++;
    if ({byte_ready, cpu_hold, load_done, err, word_count} !== 9'd0) begin
      errors++; $display("FAIL reset_mid_outputs: ready/hold/done/err/wc %b%b%b%b/%0d required all 0", byte_ready, cpu_hold, load_done, err, word_count);
    end
    for (int i = 0; i < 16; i++) begin
      a = 4'(i); #1;
      checks++;
      if (data !== 16'h9000) begin
        errors++; $display("FAIL reset_mid_mem[%0d]: got %h required 9000", i, data);
      end
    end
    repeat (2) @(negedge clk);
    byte_valid = 1'b0;
    rst_n = 1'b1; load_req = 1'b1;
    @(negedge clk); load_req = 1'b0;
    checks++;
    if (done_total != base) begin
      errors++; $display("FAIL reset_mid_no_done: pulses %0d required 0", done_total - base);
    end
    build_stream(3, 1'b1);
    run_load("reset_mid_reload", 1'b1, 1'b1);
  endtask

  initial begin
    test_reset();
    test_basic();
    test_bad_checksum();
    test_bad_length();
    test_idle_ignored();
    test_full_wrap();
    test_random();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
